// File: rtl/sa_pkg.sv
// Shared types and helpers for the systolic matrix-multiply engine.
// Optional feature macro: SA_SAT_EN enables the saturating accumulate helper.
package sa_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD,
    FLUSH,
    DRAIN
  } sa_state_e;

  localparam int SA_DIM = 8;

  // Cycles needed to push the last skewed beat through to the far corner PE.
  function automatic int flush_cyc_f(input int dim);
    return 2 * dim - 2;
  endfunction

  localparam int FLUSH_CYC = flush_cyc_f(SA_DIM);

`ifdef SA_SAT_EN
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int w);
    logic signed [63:0] s, hi, lo;
    s  = a + b;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (s > hi) return hi;
    else if (s < lo) return lo;
    return s;
  endfunction
`endif

endpackage

// File: rtl/sa_mac_pe.sv
// One systolic processing element: registered A/B pass-through plus a MAC
// accumulator. SA_SAT_EN selects saturating instead of wrapping accumulation.
module sa_mac_pe
  import sa_pkg::*;
#(
  parameter int BITS_AB = 8,
  parameter int BITS_C  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      clr,
  input  logic signed [BITS_AB-1:0] a_in,
  input  logic signed [BITS_AB-1:0] b_in,
  output logic signed [BITS_AB-1:0] a_out,
  output logic signed [BITS_AB-1:0] b_out,
  output logic signed [BITS_C-1:0]  acc
);

  logic signed [2*BITS_AB-1:0] prod;
  logic signed [BITS_C-1:0]    prod_x, acc_nxt;

  assign prod   = a_in * b_in;
  assign prod_x = BITS_C'(prod);

`ifdef SA_SAT_EN
  assign acc_nxt = BITS_C'(sat_add(64'(acc), 64'(prod_x), BITS_C));
`else
  assign acc_nxt = acc + prod_x;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else if (clr) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else if (en) begin
      a_out <= a_in;
      b_out <= b_in;
      acc   <= acc_nxt;
    end
  end

endmodule

// File: rtl/systolic_mm_engine.sv
// Self-sequencing DIMxDIM systolic matmul: skews streamed operand vectors,
// flushes the grid and drains C one row per handshake. Macro: SA_SAT_EN.
module systolic_mm_engine
  import sa_pkg::*;
#(
  parameter int BITS_AB = 8,
  parameter int BITS_C  = 16,
  parameter int DIM     = 8,
  parameter int K_MAX   = 255
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [$clog2(K_MAX+1)-1:0]        k_len,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DIM-1:0][BITS_AB-1:0]       A,
  input  logic [DIM-1:0][BITS_AB-1:0]       B,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [$clog2(DIM)-1:0]            out_row,
  output logic [DIM-1:0][BITS_C-1:0]        C_out,
  output logic                              busy,
  output logic                              done
);

  localparam int KW      = $clog2(K_MAX + 1);
  localparam int RW      = $clog2(DIM);
  localparam int FLUSH_N = flush_cyc_f(DIM);
  localparam int FW      = $clog2(FLUSH_N);

  sa_state_e          state;
  logic [KW-1:0]      k_q, beat_cnt;
  logic [FW-1:0]      fcnt;
  logic               beat, en, clr;

  logic [DIM-1:0][BITS_AB-1:0]        a_src, b_src, a_sk, b_sk;
  logic [DIM-1:0][DIM:0][BITS_AB-1:0] a_h;
  logic [DIM:0][DIM-1:0][BITS_AB-1:0] b_v;
  logic [DIM-1:0][DIM-1:0][BITS_C-1:0] acc_m;

  // The whole array, skew lines included, only moves on a beat or in flush.
  assign beat  = in_valid & in_ready;
  assign en    = beat | (state == FLUSH);
  assign clr   = (state == CLEAR);
  assign a_src = beat ? A : '0;
  assign b_src = beat ? B : '0;

  genvar g, r, c;
  generate
    for (g = 0; g < DIM; g++) begin : g_skew
      if (g == 0) begin : g_direct
        assign a_sk[0] = a_src[0];
        assign b_sk[0] = b_src[0];
      end else begin : g_delay
        logic [g-1:0][BITS_AB-1:0] a_dl, b_dl;
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            a_dl <= '0;
            b_dl <= '0;
          end else if (clr) begin
            a_dl <= '0;
            b_dl <= '0;
          end else if (en) begin
            a_dl[0] <= a_src[g];
            b_dl[0] <= b_src[g];
            for (int s = 1; s < g; s++) begin
              a_dl[s] <= a_dl[s-1];
              b_dl[s] <= b_dl[s-1];
            end
          end
        end
        assign a_sk[g] = a_dl[g-1];
        assign b_sk[g] = b_dl[g-1];
      end
      assign a_h[g][0] = a_sk[g];
      assign b_v[0][g] = b_sk[g];
    end

    for (r = 0; r < DIM; r++) begin : g_row
      for (c = 0; c < DIM; c++) begin : g_col
        sa_mac_pe #(
          .BITS_AB(BITS_AB),
          .BITS_C (BITS_C)
        ) u_pe (
          .clk  (clk),
          .rst_n(rst_n),
          .en   (en),
          .clr  (clr),
          .a_in (a_h[r][c]),
          .b_in (b_v[r][c]),
          .a_out(a_h[r][c+1]),
          .b_out(b_v[r+1][c]),
          .acc  (acc_m[r][c])
        );
      end
    end
  endgenerate

  assign C_out = out_valid ? acc_m[out_row] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      k_q       <= '0;
      beat_cnt  <= '0;
      fcnt      <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_row   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= CLEAR;
            k_q   <= (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;
            busy  <= 1'b1;
          end
        end
        CLEAR: begin
          beat_cnt <= '0;
          fcnt     <= '0;
          if (k_q == '0) begin
            state <= FLUSH;
          end else begin
            state    <= LOAD;
            in_ready <= 1'b1;
          end
        end
        LOAD: begin
          if (beat) begin
            if (beat_cnt == k_q - 1'b1) begin
              state    <= FLUSH;
              in_ready <= 1'b0;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        FLUSH: begin
          if (fcnt == FW'(FLUSH_N - 1)) begin
            state     <= DRAIN;
            out_valid <= 1'b1;
          end else begin
            fcnt <= fcnt + 1'b1;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (out_row == RW'(DIM - 1)) begin
              state     <= IDLE;
              out_valid <= 1'b0;
              out_row   <= '0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              out_row <= out_row + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_mm_engine.sv
// Directed bench for systolic_mm_engine at DIM=8: identity matmul, gaps,
// back-pressure, saturation/wrap, k_len=0 and mid-job reset.
module tb_systolic_mm_engine;

  localparam int DIM = 8;
  localparam int BA  = 8;
  localparam int BC  = 16;
  localparam int KM  = 255;
  localparam int KW  = 8;
  localparam int RW  = 3;

  typedef logic [DIM-1:0][BA-1:0] vec_t;
  typedef logic [DIM-1:0][BC-1:0] row_t;

  logic          clk = 1'b0;
  logic          rst_n, start, in_valid, in_ready, out_valid, out_ready, busy, done;
  logic [KW-1:0] k_len;
  vec_t          A, B;
  logic [RW-1:0] out_row;
  row_t          C_out;

  systolic_mm_engine #(
    .BITS_AB(BA), .BITS_C(BC), .DIM(DIM), .K_MAX(KM)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len),
    .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .C_out(C_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  row_t got_c[DIM];
  int   got_r[DIM];
  int   nrows, ndone, nunstable, lat;
  logic ir_after, done_after, busy_after;

  function automatic vec_t beat_a(input int mode, input int b);
    vec_t v;
    for (int i = 0; i < DIM; i++) v[i] = (mode == 0) ? ((i == b) ? 8'd1 : 8'd0) : 8'd127;
    return v;
  endfunction

  function automatic vec_t beat_b(input int mode, input int b);
    vec_t v;
    for (int j = 0; j < DIM; j++) v[j] = (mode == 0) ? 8'(8 * b + j) : 8'd127;
    return v;
  endfunction

  // Identity A times B[k][j]=8k+j reproduces B: row r holds 8r..8r+7.
  function automatic row_t ident_row(input int r);
    row_t v;
    for (int j = 0; j < DIM; j++) v[j] = 16'(8 * r + j);
    return v;
  endfunction

  task automatic start_job(input int k);
    @(negedge clk);
    start = 1'b1;
    k_len = k[KW-1:0];
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Streams k beats (gap=1: in_valid pattern 1,0,0 repeating), keeps in_valid
  // high one extra cycle, then counts edges until out_valid is sampled high.
  task automatic send_beats(input int k, input int mode, input bit gap, output int lat_o);
    int  b, cyc, t, cnt;
    bit  hs;
    b = 0; cyc = 0; t = 0; lat_o = -1;
    while (b < k && t < 500) begin
      @(negedge clk);
      in_valid = gap ? (cyc % 3 == 0) : 1'b1;
      cyc++;
      if (in_valid) begin
        A = beat_a(mode, b);
        B = beat_b(mode, b);
      end else begin
        A = {$urandom, $urandom};
        B = {$urandom, $urandom};
      end
      hs = in_valid & in_ready;
      @(posedge clk);
      t++;
      if (hs) b++;
    end
    cnt = 0;
    while (cnt < 60) begin
      @(negedge clk);
      if (cnt == 0) begin
        ir_after = in_ready;
        in_valid = 1'b1;
        A = {$urandom, $urandom};
        B = {$urandom, $urandom};
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid) begin
        lat_o = cnt + 1;
        break;
      end
      @(posedge clk);
      cnt++;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input int stall_row, input int stall_len, input bit poke_start);
    int   stalls, t;
    row_t snap_c;
    logic [RW-1:0] snap_r;
    nrows = 0; ndone = 0; nunstable = 0; stalls = 0; t = 0;
    while (nrows < DIM && t < 200) begin
      @(negedge clk);
      t++;
      if (done) ndone++;
      if (poke_start) begin
        start = (nrows == 2);
        k_len = 8'd5;
      end
      out_ready = 1'b1;
      if (out_valid) begin
        if (int'(out_row) == stall_row && stalls < stall_len) begin
          out_ready = 1'b0;
          if (stalls == 0) begin
            snap_c = C_out;
            snap_r = out_row;
          end else if (C_out !== snap_c || out_row !== snap_r) begin
            nunstable++;
          end
          stalls++;
        end else begin
          got_r[nrows] = int'(out_row);
          got_c[nrows] = C_out;
          nrows++;
        end
      end
      @(posedge clk);
    end
    #1;
    start = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    done_after = done;
    busy_after = busy;
    if (done) ndone++;
    @(negedge clk);
    if (done) ndone++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    n_cmp++;
    if (out_row !== 3'd0) begin n_bad++; $display("FAIL reset_out_row got=%0d want=0", out_row); end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_cmp++;
    if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b want=0", done); end
    n_cmp++;
    if (C_out !== '0) begin n_bad++; $display("FAIL reset_c_out got=%h want=0", C_out); end
    n_cmp++;
  endtask

  task automatic test_identity();
    start_job(8);
    @(negedge clk);
    if (busy !== 1'b1) begin n_bad++; $display("FAIL id_busy_t1 got=%b want=1", busy); end
    n_cmp++;
    if (in_ready !== 1'b0) begin n_bad++; $display("FAIL id_in_ready_clear got=%b want=0", in_ready); end
    n_cmp++;
    @(negedge clk);
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL id_in_ready_t2 got=%b want=1", in_ready); end
    n_cmp++;
    send_beats(8, 0, 1'b0, lat);
    if (lat !== 15) begin n_bad++; $display("FAIL id_latency got=%0d want=15", lat); end
    n_cmp++;
    if (ir_after !== 1'b0) begin n_bad++; $display("FAIL id_in_ready_drop got=%b want=0", ir_after); end
    n_cmp++;
    drain(-1, 0, 1'b0);
    for (int r = 0; r < DIM; r++) begin
      if (got_r[r] !== r || got_c[r] !== ident_row(r)) begin
        n_bad++;
        $display("FAIL id_row%0d got row=%0d data=%h want row=%0d data=%h", r, got_r[r], got_c[r], r, ident_row(r));
      end
      n_cmp++;
    end
    if (done_after !== 1'b1 || busy_after !== 1'b0) begin
      n_bad++; $display("FAIL id_done_busy got done=%b busy=%b want done=1 busy=0", done_after, busy_after);
    end
    n_cmp++;
    if (ndone !== 1) begin n_bad++; $display("FAIL id_done_count got=%0d want=1", ndone); end
    n_cmp++;
  endtask

  task automatic test_gaps();
    start_job(8);
    send_beats(8, 0, 1'b1, lat);
    if (lat !== 15) begin n_bad++; $display("FAIL gap_latency got=%0d want=15", lat); end
    n_cmp++;
    drain(-1, 0, 1'b0);
    for (int r = 0; r < DIM; r++) begin
      if (got_c[r] !== ident_row(r)) begin
        n_bad++; $display("FAIL gap_row%0d got=%h want=%h", r, got_c[r], ident_row(r));
      end
      n_cmp++;
    end
  endtask

  task automatic test_back_to_back();
    start_job(8);
    send_beats(8, 0, 1'b0, lat);
    drain(3, 5, 1'b0);
    if (nunstable !== 0) begin n_bad++; $display("FAIL bp_stable got=%0d changes want=0", nunstable); end
    n_cmp++;
    for (int r = 0; r < DIM; r++) begin
      if (got_r[r] !== r) begin n_bad++; $display("FAIL bp_order%0d got=%0d want=%0d", r, got_r[r], r); end
      n_cmp++;
    end
    if (got_c[3] !== ident_row(3)) begin n_bad++; $display("FAIL bp_row3 got=%h want=%h", got_c[3], ident_row(3)); end
    n_cmp++;
    if (ndone !== 1) begin n_bad++; $display("FAIL bp_done_count got=%0d want=1", ndone); end
    n_cmp++;
  endtask

  task automatic test_saturation();
    row_t exp_row;
    // 4 * 127 * 127 = 64516: clamps to 32767, or wraps to -1020 (0xFC04).
`ifdef SA_SAT_EN
    for (int j = 0; j < DIM; j++) exp_row[j] = 16'h7FFF;
`else
    for (int j = 0; j < DIM; j++) exp_row[j] = 16'hFC04;
`endif
    start_job(4);
    send_beats(4, 1, 1'b0, lat);
    drain(-1, 0, 1'b0);
    for (int r = 0; r < DIM; r++) begin
      if (got_c[r] !== exp_row) begin n_bad++; $display("FAIL sat_row%0d got=%h want=%h", r, got_c[r], exp_row); end
      n_cmp++;
    end
  endtask

  task automatic test_k0();
    start_job(0);
    send_beats(0, 0, 1'b0, lat);
    if (lat < 0) begin n_bad++; $display("FAIL k0_out_valid got=timeout want=rise"); end
    n_cmp++;
    drain(-1, 0, 1'b1);
    if (nrows !== DIM) begin n_bad++; $display("FAIL k0_rows got=%0d want=%0d", nrows, DIM); end
    n_cmp++;
    for (int r = 0; r < DIM; r++) begin
      if (got_c[r] !== '0) begin n_bad++; $display("FAIL k0_row%0d got=%h want=0", r, got_c[r]); end
      n_cmp++;
    end
    if (ndone !== 1) begin n_bad++; $display("FAIL k0_done_count got=%0d want=1", ndone); end
    n_cmp++;
    repeat (3) @(negedge clk);
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL k0_start_ignored got busy=%b out_valid=%b want 0 0", busy, out_valid);
    end
    n_cmp++;
  endtask

  task automatic test_reset_mid();
    start_job(8);
    @(negedge clk);
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      in_valid = 1'b1;
      A = beat_a(0, b);
      B = beat_b(0, b);
      if (b == 2) rst_n = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    if (in_ready !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0 || out_row !== 3'd0) begin
      n_bad++;
      $display("FAIL rst_mid_ctrl got in_ready=%b busy=%b out_valid=%b done=%b out_row=%0d want all 0",
               in_ready, busy, out_valid, done, out_row);
    end
    n_cmp++;
    if (C_out !== '0) begin n_bad++; $display("FAIL rst_mid_c_out got=%h want=0", C_out); end
    n_cmp++;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL rst_mid_no_output got out_valid=%b busy=%b want 0 0", out_valid, busy);
    end
    n_cmp++;
    start_job(8);
    send_beats(8, 0, 1'b0, lat);
    drain(-1, 0, 1'b0);
    for (int r = 0; r < DIM; r++) begin
      if (got_c[r] !== ident_row(r)) begin
        n_bad++; $display("FAIL rst_mid_row%0d got=%h want=%h", r, got_c[r], ident_row(r));
      end
      n_cmp++;
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; k_len = '0; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_identity();
    test_gaps();
    test_back_to_back();
    test_saturation();
    test_k0();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
